// File: rtl/serial_nibble_collector_if.sv
// Bus between the upstream serial source / downstream consumer and the nibble collector.
// The master drives serial bits, flush and ready; the slave returns the FIFO head and status.
interface serial_nibble_collector_if;
    logic       si;
    logic       si_valid;
    logic       clr;
    logic       dout_ready;
    logic [3:0] dout;
    logic       dout_valid;
    logic [2:0] count;
    logic [1:0] bit_cnt;
    logic       full;
    logic       overflow;

    modport master (
        output si, si_valid, clr, dout_ready,
        input  dout, dout_valid, count, bit_cnt, full, overflow
    );

    modport slave (
        input  si, si_valid, clr, dout_ready,
        output dout, dout_valid, count, bit_cnt, full, overflow
    );
endinterface

// File: rtl/serial_nibble_collector.sv
// Assembles LSB-first serial bits into nibbles and queues them in a small FIFO.
// The head entry is presented combinationally; a full FIFO drops new nibbles and sets a sticky overflow.
module serial_nibble_collector #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    serial_nibble_collector_if.slave  bus
);
    logic [3:0] mem_q [DEPTH];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic [1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] asm_q, asm_d;
    logic       overflow_q, overflow_d;

    logic       nib_done;
    logic       pop;
    logic       push;
    logic [3:0] nib;

    always_comb begin
        nib_done = bus.si_valid && (bit_cnt_q == 2'd3);
        nib      = {bus.si, asm_q};
        pop      = (count_q != 3'd0) && bus.dout_ready;
        // A full FIFO still accepts a nibble when the head leaves on the same edge.
        push     = nib_done && ((count_q != 3'(DEPTH)) || pop) && !bus.clr;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        bit_cnt_d  = bit_cnt_q;
        asm_d      = asm_q;
        overflow_d = overflow_q;

        if (bus.clr) begin
            wr_ptr_d   = 2'd0;
            rd_ptr_d   = 2'd0;
            count_d    = 3'd0;
            bit_cnt_d  = 2'd0;
            asm_d      = 3'd0;
            overflow_d = 1'b0;
        end else begin
            if (bus.si_valid) begin
                bit_cnt_d = bit_cnt_q + 2'd1;
                if (nib_done) begin
                    asm_d = 3'd0;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        if (bit_cnt_q == 2'(i)) begin
                            asm_d[i] = bus.si;
                        end
                    end
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
            count_d = count_q + {2'b00, push} - {2'b00, pop};
            if (nib_done && !push) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            bit_cnt_q  <= 2'd0;
            asm_q      <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            bit_cnt_q  <= bit_cnt_d;
            asm_q      <= asm_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; dout is masked while the FIFO is empty.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!rst && push && (wr_ptr_q == 2'(gi))) begin
                    mem_q[gi] <= nib;
                end
            end
        end
    endgenerate

    assign bus.dout_valid = (count_q != 3'd0);
    assign bus.dout       = bus.dout_valid ? mem_q[rd_ptr_q] : 4'b0000;
    assign bus.count      = count_q;
    assign bus.bit_cnt    = bit_cnt_q;
    assign bus.full       = (count_q == 3'(DEPTH));
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_serial_nibble_collector.sv
// Directed bench for serial_nibble_collector: a queue-based model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_serial_nibble_collector;
    logic clk;
    logic rst;

    serial_nibble_collector_if bus ();

    serial_nibble_collector #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    logic [3:0] mq [$];
    bit         mbits [$];
    bit         movf;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("check %s value=%0d ok", name, act);
        end
    endtask

    // One clock edge with the given inputs; the model advances right after the edge.
    task automatic step(input bit s, input bit v, input bit r, input bit c, input bit rs);
        bit         popped;
        logic [3:0] nib;
        bus.si         = s;
        bus.si_valid   = v;
        bus.dout_ready = r;
        bus.clr        = c;
        rst            = rs;
        @(posedge clk);
        cyc++;
        if (rs || c) begin
            mq.delete();
            mbits.delete();
            movf = 1'b0;
        end else begin
            popped = (mq.size() != 0) && r;
            if (popped) void'(mq.pop_front());
            if (v) begin
                mbits.push_back(s);
                if (mbits.size() == 4) begin
                    nib = {mbits[3], mbits[2], mbits[1], mbits[0]};
                    mbits.delete();
                    if (mq.size() < 4) mq.push_back(nib);
                    else movf = 1'b1;
                end
            end
        end
        @(negedge clk);
        $display("cyc=%0d si=%0b v=%0b rdy=%0b clr=%0b rst=%0b -> dout=%b valid=%0b count=%0d bit_cnt=%0d ovf=%0b",
                 cyc, s, v, r, c, rs, bus.dout, bus.dout_valid, bus.count, bus.bit_cnt, bus.overflow);
    endtask

    task automatic send_nib(input logic [3:0] n, input bit r);
        for (int i = 0; i < 4; i++) step(n[i], 1'b1, r, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit r);
        step(1'b0, 1'b0, r, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (bus.dout_valid !== (mq.size() != 0) ||
                bus.count      !== 3'(mq.size()) ||
                bus.bit_cnt    !== 2'(mbits.size()) ||
                bus.full       !== (mq.size() == 4) ||
                bus.overflow   !== movf ||
                (mq.size() != 0 && bus.dout !== mq[0])) begin
                failures++;
                $display("FAIL model_cmp cyc=%0d actual dout=%b valid=%0b count=%0d bit_cnt=%0d full=%0b ovf=%0b required dout=%b valid=%0b count=%0d bit_cnt=%0d full=%0b ovf=%0b",
                         cyc, bus.dout, bus.dout_valid, bus.count, bus.bit_cnt, bus.full, bus.overflow,
                         (mq.size() != 0) ? mq[0] : 4'b0000, (mq.size() != 0), mq.size(),
                         mbits.size(), (mq.size() == 4), movf);
            end
        end
    end

    initial begin
        bus.si = 1'b0; bus.si_valid = 1'b0; bus.dout_ready = 1'b0; bus.clr = 1'b0; rst = 1'b1;
        do_reset();
        do_reset();
        cmp_en = 1'b1;
        chk("rst_valid", int'(bus.dout_valid), 0);
        chk("rst_dout", int'(bus.dout), 0);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_ovf", int'(bus.overflow), 0);

        // First nibble, LSB-first 1,0,0,1
        send_nib(4'b1001, 1'b0);
        chk("first_dout", int'(bus.dout), 4'b1001);
        chk("first_valid", int'(bus.dout_valid), 1);
        chk("first_count", int'(bus.count), 1);
        chk("first_bitcnt", int'(bus.bit_cnt), 0);

        // Fill, overflow, then drain in order
        do_reset();
        send_nib(4'b1001, 1'b0);
        send_nib(4'b0011, 1'b0);
        send_nib(4'b1101, 1'b0);
        send_nib(4'b0100, 1'b0);
        send_nib(4'b1111, 1'b0);
        chk("ovf_full", int'(bus.full), 1);
        chk("ovf_count", int'(bus.count), 4);
        chk("ovf_flag", int'(bus.overflow), 1);
        chk("ovf_bitcnt", int'(bus.bit_cnt), 0);
        chk("drain0", int'(bus.dout), 4'b1001);
        idle(1'b1);
        chk("drain1", int'(bus.dout), 4'b0011);
        idle(1'b1);
        chk("drain2", int'(bus.dout), 4'b1101);
        idle(1'b1);
        chk("drain3", int'(bus.dout), 4'b0100);
        idle(1'b1);
        chk("drain_empty", int'(bus.dout_valid), 0);
        idle(1'b1);
        chk("pop_empty_noeffect", int'(bus.count), 0);
        chk("ovf_sticky", int'(bus.overflow), 1);

        // Push and pop on the same edge while full
        do_reset();
        send_nib(4'b1001, 1'b0);
        send_nib(4'b0011, 1'b0);
        send_nib(4'b1101, 1'b0);
        send_nib(4'b0100, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("pp_count", int'(bus.count), 4);
        chk("pp_ovf", int'(bus.overflow), 0);
        chk("pp_head", int'(bus.dout), 4'b0011);
        idle(1'b1); idle(1'b1); idle(1'b1);
        chk("pp_tail", int'(bus.dout), 4'b0110);
        idle(1'b1);

        // Continuous stream with dout_ready held high
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'(i % 3 == 0), 1'b1, 1'b1, 1'b0, 1'b0);
            chk("stream_count_le1", int'(bus.count <= 3'd1), 1);
        end
        chk("stream_ovf", int'(bus.overflow), 0);

        // Gap in si_valid holds partial bits
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0); idle(1'b0); idle(1'b0);
        chk("gap_bitcnt", int'(bus.bit_cnt), 2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("gap_dout", int'(bus.dout), 4'b1101);

        // clr mid-nibble, asserted together with si_valid and dout_ready
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_count", int'(bus.count), 0);
        chk("clr_bitcnt", int'(bus.bit_cnt), 0);
        send_nib(4'b1111, 1'b0);
        chk("clr_dout", int'(bus.dout), 4'b1111);
        chk("clr_after_count", int'(bus.count), 1);
        chk("clr_after_ovf", int'(bus.overflow), 0);

        // rst mid-nibble, asserted together with clr and si_valid
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_mid_bitcnt", int'(bus.bit_cnt), 0);
        send_nib(4'b1111, 1'b0);
        chk("rst_dout", int'(bus.dout), 4'b1111);
        chk("rst_after_count", int'(bus.count), 1);
        chk("rst_after_ovf", int'(bus.overflow), 0);

        // Mixed traffic checked only by the model
        for (int i = 0; i < 120; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 40) == 0), 1'b0);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_nibble_collector.md
SERIAL_NIBBLE_COLLECTOR -- requirements
Module: serial_nibble_collector

Interface
REQ-001 Parameter DEPTH, default 4, number of nibble entries in the output FIFO; fixed at 4 for this revision.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 si  input  1  serial data bit from the upstream shift register's serial output.
REQ-005 si_valid  input  1  qualifies si; high while upstream is in a shift mode.
REQ-006 clr  input  1  synchronous flush of assembly and FIFO state.
REQ-007 dout_ready  input  1  downstream accepts head nibble.
REQ-008 dout  output  4  head-of-FIFO nibble.
REQ-009 dout_valid  output  1  FIFO non-empty.
REQ-010 count  output  3  FIFO occupancy, 0..4.
REQ-011 bit_cnt  output  2  bits collected toward the current nibble, 0..3.
REQ-012 full  output  1  count == 4.
REQ-013 overflow  output  1  sticky flag, completed nibble dropped.

Function
REQ-014 On a clk edge with si_valid=1, si shall be written into assembly bit position bit_cnt (LSB-first: first bit received is bit 0), and bit_cnt shall increment modulo 4.
REQ-015 With si_valid=0, the assembly register and bit_cnt shall hold.
REQ-016 A nibble completes on the edge where si_valid=1 and bit_cnt==3; the completed value {si, asm[2:0]} shall be pushed on that same edge, and bit_cnt shall wrap to 0.
REQ-017 Pop occurs on an edge where dout_valid=1 and dout_ready=1; dout_ready with dout_valid=0 shall have no effect.
REQ-018 dout_valid=(count!=0); dout shall always present the oldest entry, combinationally from FIFO storage, with no extra pipeline stage.
REQ-019 Push-to-visible latency: a nibble pushed into an empty FIFO shall appear on dout with dout_valid=1 immediately after the push edge.
REQ-020 Push and pop on the same edge: count unchanged, both performed, including when count==4.
REQ-021 Push when count==4 with no simultaneous pop: nibble dropped, FIFO contents unchanged, overflow set to 1; bit_cnt still wraps to 0.
REQ-022 overflow shall remain 1 until rst or clr.
REQ-023 Read/write pointers shall be 2-bit, wrapping 3->0; count is tracked separately (0..4).
REQ-024 clr=1 shall, on the edge, set bit_cnt=0, the assembly register to 0, count=0, both pointers to 0, and overflow=0; it takes priority over si_valid and pop on that edge.
REQ-025 full=(count==4).

Reset
REQ-026 rst=1 at a clock edge shall set bit_cnt=0, assembly=0, count=0, pointers=0, overflow=0; outputs dout_valid=0, full=0, and dout=4'b0000.
REQ-027 rst shall take priority over clr, si_valid, and dout_ready.
REQ-028 Reset asserted mid-nibble shall discard any partial bits; collection restarts at bit 0 after release.

Verification
REQ-029 After reset, with dout_ready=0, apply si_valid=1 and si=1,0,0,1 over 4 edges -> dout=4'b1001, dout_valid=1, count=1, bit_cnt=0.
REQ-030 With dout_ready=0, apply 16 bits forming the nibbles 1001, 0011, 1101, 0100, then 4 more bits -> full=1, count=4, overflow=1, dout=4'b1001; pop 4 times -> dout outputs 1001, 0011, 1101, 0100 in order, then dout_valid=0.
REQ-031 Hold dout_ready=1 while streaming bits continuously -> each nibble is popped on the edge after its push, count never exceeds 1, overflow=0.
REQ-032 With FIFO full, complete a nibble on the same edge as a pop -> count stays 4, no overflow, new nibble becomes the tail.
REQ-033 Send 2 bits, deassert si_valid for 3 cycles, then send 2 more bits -> bits are held across the gap and the nibble is assembled correctly.
REQ-034 Send 2 bits, then pulse clr (separately, pulse rst), then send 1,1,1,1 -> dout=4'b1111, count=1, overflow=0.
